// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared types and wdata packing for the SCCB configuration sequencer
package sccb_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        ID_RD,
        LOAD,
        XFER,
        GAP,
        NEXT,
        DONE,
        ERROR
    } cfg_state_t;

    localparam logic [7:0] ERR_ID_INDEX = 8'hFF;
    localparam int         WDATA_W      = 40;

    // Controller frame: {read address, write address, sub-address, data}
    function automatic logic [WDATA_W-1:0] pack_wdata(input logic [7:0]  slave_addr,
                                                      input logic [15:0] sub_addr,
                                                      input logic [7:0]  data);
        return {slave_addr | 8'h01, slave_addr, sub_addr, data};
    endfunction

endpackage

// File: rtl/sccb_cfg_sequencer_if.sv
// rtl/sccb_cfg_sequencer_if.sv - byte-level SCCB controller request/response bundle
interface sccb_cfg_sequencer_if;
    import sccb_pkg::*;

    logic               i2c_trans;
    logic               i2c_wr;
    logic [WDATA_W-1:0] i2c_wdata;
    logic               i2c_end;
    logic               i2c_ack;
    logic [7:0]         i2c_rdata;

    modport master (
        output i2c_trans, i2c_wr, i2c_wdata,
        input  i2c_end, i2c_ack, i2c_rdata
    );

    modport slave (
        input  i2c_trans, i2c_wr, i2c_wdata,
        output i2c_end, i2c_ack, i2c_rdata
    );

endinterface

// File: rtl/sccb_delay_cnt.sv
// rtl/sccb_delay_cnt.sv - loadable down-counter shared by power-up wait and inter-transaction gap
module sccb_delay_cnt #(
    parameter int               WIDTH     = 20,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// rtl/sccb_cfg_sequencer.sv - walks the OV5640 init table through the SCCB byte controller
module sccb_cfg_sequencer
    import sccb_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR = 8'h78,
    parameter int          LUT_SIZE   = 252,
    parameter logic [19:0] PWR_DELAY  = 20'd1_000_000,
    parameter logic [15:0] GAP_CYCLES = 16'd500,
    parameter int          MAX_RETRY  = 3,
    parameter bit          CHECK_ID   = 1'b1,
    parameter logic [15:0] ID_REG     = 16'h300A,
    parameter logic [7:0]  ID_VAL     = 8'h56
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [7:0]                  lut_index,
    input  logic [23:0]                 lut_data,
    sccb_cfg_sequencer_if.master        bus,
    output logic                        cfg_busy,
    output logic                        cfg_done,
    output logic                        cfg_error,
    output logic [7:0]                  err_index
);

    localparam int         RW       = $clog2(MAX_RETRY + 2);
    localparam logic [7:0] LUT_LAST = 8'(LUT_SIZE);

    if (LUT_SIZE < 1 || LUT_SIZE > 255) begin : g_lut_size_check
        $error("sccb_cfg_sequencer: LUT_SIZE must be 1..255");
    end

    cfg_state_t    state, state_next;
    logic [7:0]    idx;
    logic [RW-1:0] retry;
    logic          id_ok;
    logic          load_ph;
    logic [23:0]   ld_reg;
    logic          cnt_zero, cnt_load;
    logic          idx_inc, retry_inc, retry_clr, id_pass, latch, set_done, set_err, restart;

    sccb_delay_cnt #(.WIDTH(20), .RESET_VAL(PWR_DELAY)) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val ({4'd0, GAP_CYCLES}),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PWR_WAIT;
        else        state <= state_next;
    end

    // Waits that end in a new transfer also require i2c_end low, so trans never rises over a stale end
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        idx_inc    = 1'b0;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        id_pass    = 1'b0;
        latch      = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        restart    = 1'b0;
        case (state)
            PWR_WAIT: if (cnt_zero && !bus.i2c_end) state_next = CHECK_ID ? ID_RD : LOAD;
            ID_RD: if (bus.i2c_end) begin
                cnt_load   = 1'b1;
                state_next = GAP;
                if (!bus.i2c_ack && bus.i2c_rdata == ID_VAL) begin
                    id_pass   = 1'b1;
                    retry_clr = 1'b1;
                end else begin
                    retry_inc = 1'b1;
                end
            end
            LOAD: if (load_ph && !bus.i2c_end) begin
                latch      = 1'b1;
                state_next = XFER;
            end
            XFER: if (bus.i2c_end) begin
                cnt_load   = 1'b1;
                state_next = GAP;
                if (!bus.i2c_ack) begin
                    retry_clr = 1'b1;
                    idx_inc   = 1'b1;
                end else begin
                    retry_inc = 1'b1;
                end
            end
            GAP: if (cnt_zero && !bus.i2c_end) state_next = NEXT;
            NEXT: begin
                if (retry > RW'(MAX_RETRY)) begin
                    set_err    = 1'b1;
                    state_next = ERROR;
                end else if (!id_ok) begin
                    state_next = ID_RD;
                end else if (idx == LUT_LAST) begin
                    set_done   = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = LOAD;
                end
            end
            DONE, ERROR: if (start) begin
                restart    = 1'b1;
                cnt_load   = 1'b1;
                state_next = PWR_WAIT;
            end
            default: state_next = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 8'd0;
            retry     <= '0;
            id_ok     <= !CHECK_ID;
            load_ph   <= 1'b0;
            ld_reg    <= 24'd0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            err_index <= 8'd0;
        end else begin
            load_ph  <= (state == LOAD) && (state_next == LOAD);
            cfg_busy <= (state_next != DONE) && (state_next != ERROR);
            if (restart) begin
                idx       <= 8'd0;
                retry     <= '0;
                id_ok     <= !CHECK_ID;
                cfg_done  <= 1'b0;
                cfg_error <= 1'b0;
            end
            if (idx_inc)   idx    <= idx + 8'd1;
            if (retry_clr) retry  <= '0;
            if (retry_inc) retry  <= retry + RW'(1);
            if (id_pass)   id_ok  <= 1'b1;
            if (latch)     ld_reg <= lut_data;
            if (set_done)  cfg_done <= 1'b1;
            if (set_err) begin
                cfg_error <= 1'b1;
                err_index <= id_ok ? idx : ERR_ID_INDEX;
            end
        end
    end

    assign lut_index     = idx;
    assign bus.i2c_trans = (state == ID_RD) || (state == XFER);
    assign bus.i2c_wr    = (state == XFER);
    assign bus.i2c_wdata = (state == ID_RD) ? pack_wdata(SLAVE_ADDR, ID_REG, 8'h00)
                         : (state == XFER)  ? pack_wdata(SLAVE_ADDR, ld_reg[23:8], ld_reg[7:0])
                         : '0;

endmodule
